// File: rtl/buzz_pkg.sv
// buzz_pkg: shared types for the buzzer scheduler (states, source codes, beep patterns).
package buzz_pkg;
  typedef enum logic [1:0] {IDLE, ON, OFF} state_e;
  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_CLICK = 2'd1;
  localparam logic [1:0] SRC_ALARM = 2'd2;
  localparam logic [1:0] SRC_ERR = 2'd3;
  localparam int PAT_W = 16;
  typedef struct packed {
    logic [PAT_W-1:0] n;
    logic [PAT_W-1:0] on_t;
    logic [PAT_W-1:0] off_t;
  } pattern_t;
  function automatic pattern_t mk_pat(input int n, input int on_t, input int off_t);
    return '{n: PAT_W'(n), on_t: PAT_W'(on_t), off_t: PAT_W'(off_t)};
  endfunction
endpackage

// File: rtl/buzz_phase_timer.sv
// buzz_phase_timer: phase down-counter plus beep counter for the active pattern.
module buzz_phase_timer
  import buzz_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     load_i,
  input  logic     first_i,
  input  state_e   phase_i,
  input  pattern_t pat_i,
  output logic     phase_expired_o,
  output logic     last_beep_o
);
  logic [CNT_W-1:0] timer_q, timer_d, beep_q, beep_d, len;
  always_comb begin
    len = phase_i == ON ? pat_i.on_t[CNT_W-1:0] : pat_i.off_t[CNT_W-1:0];
    timer_d = load_i ? len - CNT_W'(1) : timer_q - CNT_W'(timer_q != '0);
    beep_d = (load_i && phase_i == ON) ? (first_i ? CNT_W'(1) : beep_q + CNT_W'(1)) : beep_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      beep_q <= '0;
    end else begin
      timer_q <= timer_d;
      beep_q <= beep_d;
    end
  end
  assign phase_expired_o = timer_q == '0;
  assign last_beep_o = beep_q == pat_i.n[CNT_W-1:0];
endmodule

// File: rtl/buzz_sched.sv
// buzz_sched: latches buzzer requests, grants by fixed priority (err > alarm > click)
// with preemption, and sequences the granted beep pattern onto the buzz level.
module buzz_sched
  import buzz_pkg::*;
#(
  parameter int CNT_W = 10,
  parameter int CLICK_N = 1,
  parameter int CLICK_ON = 30,
  parameter int CLICK_OFF = 30,
  parameter int ALARM_N = 3,
  parameter int ALARM_ON = 200,
  parameter int ALARM_OFF = 200,
  parameter int ERR_N = 5,
  parameter int ERR_ON = 100,
  parameter int ERR_OFF = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_click,
  input  logic       req_alarm,
  input  logic       req_err,
  input  logic       mute,
  output logic       buzz,
  output logic       busy,
  output logic [1:0] src,
  output logic       done
);
  localparam int LIM = 1 << CNT_W;
  if (CNT_W < 1 || CNT_W > PAT_W || CLICK_N < 1 || CLICK_ON < 1 || CLICK_OFF < 1 ||
      ALARM_N < 1 || ALARM_ON < 1 || ALARM_OFF < 1 || ERR_N < 1 || ERR_ON < 1 || ERR_OFF < 1 ||
      CLICK_N >= LIM || CLICK_ON >= LIM || CLICK_OFF >= LIM || ALARM_N >= LIM ||
      ALARM_ON >= LIM || ALARM_OFF >= LIM || ERR_N >= LIM || ERR_ON >= LIM || ERR_OFF >= LIM)
  begin : g_bad_param
    $error("buzz_sched: pattern parameters must be nonzero and below 2**CNT_W");
  end
  localparam pattern_t P_CLICK = mk_pat(CLICK_N, CLICK_ON, CLICK_OFF);
  localparam pattern_t P_ALARM = mk_pat(ALARM_N, ALARM_ON, ALARM_OFF);
  localparam pattern_t P_ERR = mk_pat(ERR_N, ERR_ON, ERR_OFF);
  state_e state_q, phase;
  logic [1:0] src_q, win, sel;
  logic [2:0] pend_q, pend_d, clr;
  logic grant, load, exp_w, last_w, buzz_q, done_q;
  pattern_t pat;
  // src_q is SRC_NONE in IDLE, so one compare covers both idle grant and preemption
  always_comb begin
    win = pend_q[2] ? SRC_ERR : pend_q[1] ? SRC_ALARM : pend_q[0] ? SRC_CLICK : SRC_NONE;
    grant = win > src_q;
    clr = {win == SRC_ERR, win == SRC_ALARM, win == SRC_CLICK} & {3{grant}};
    pend_d = (pend_q & ~clr) | {req_err, req_alarm, req_click};
    sel = grant ? win : src_q;
    pat = sel == SRC_ERR ? P_ERR : sel == SRC_ALARM ? P_ALARM : P_CLICK;
    load = grant || (exp_w && (state_q == ON || (state_q == OFF && !last_w)));
    phase = (grant || state_q == OFF) ? ON : OFF;
  end
  buzz_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk            (clk),
    .rst            (rst),
    .load_i         (load),
    .first_i        (grant),
    .phase_i        (phase),
    .pat_i          (pat),
    .phase_expired_o(exp_w),
    .last_beep_o    (last_w)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q <= SRC_NONE;
      pend_q <= '0;
      buzz_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      done_q <= 1'b0;
      if (grant) begin
        state_q <= ON;
        src_q <= win;
        buzz_q <= ~mute;
      end else if (state_q == ON) begin
        buzz_q <= ~mute && !exp_w;
        if (exp_w) state_q <= OFF;
      end else if (state_q == OFF && exp_w) begin
        state_q <= last_w ? IDLE : ON;
        src_q <= last_w ? SRC_NONE : src_q;
        buzz_q <= ~mute && !last_w;
        done_q <= last_w;
      end else begin
        buzz_q <= 1'b0;
      end
    end
  end
  assign buzz = buzz_q;
  assign busy = state_q != IDLE;
  assign src = src_q;
  assign done = done_q;
endmodule

// File: tb/tb_buzz_sched.sv
// tb_buzz_sched: directed and random stimulus checked each cycle against a
// pattern-position model of the scheduler.
module tb_buzz_sched;
  logic clk = 1'b0;
  logic rst, rc, ra, re, mute;
  logic buzz, busy, done;
  logic [1:0] src;
  int n_chk = 0, n_fail = 0, edge_n = 0;
  int mn[4] = '{0, 1, 3, 5};
  int mon[4] = '{0, 30, 200, 100};
  int moff[4] = '{0, 30, 200, 100};
  logic [3:0] pend = '0;
  int act = 0, t = 0, win;
  logic m_buzz = 1'b0, m_done = 1'b0;

  buzz_sched dut (
    .clk(clk), .rst(rst), .req_click(rc), .req_alarm(ra), .req_err(re),
    .mute(mute), .buzz(buzz), .busy(busy), .src(src), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, edge_n, got, exp);
    end
  endtask

  // Model: act is the pattern in service, t the cycle offset since its grant.
  task automatic tick(input logic r_i, input logic c_i, input logic a_i, input logic e_i,
                      input logic m_i);
    rst = r_i; rc = c_i; ra = a_i; re = e_i; mute = m_i;
    @(posedge clk);
    m_done = 1'b0;
    if (r_i) begin
      pend = '0; act = 0; t = 0;
    end else begin
      win = pend[3] ? 3 : pend[2] ? 2 : pend[1] ? 1 : 0;
      if (win > act) begin
        act = win; t = 0; pend[win] = 1'b0;
      end else if (act != 0) begin
        t++;
        if (t == mn[act] * (mon[act] + moff[act])) begin
          act = 0; m_done = 1'b1;
        end
      end
      pend = pend | {e_i, a_i, c_i, 1'b0};
    end
    m_buzz = (act == 0) ? 1'b0 : ((t % (mon[act] + moff[act])) < mon[act]) && !m_i;
    #1;
    chk("buzz", {1'b0, buzz}, {1'b0, m_buzz});
    chk("busy", {1'b0, busy}, {1'b0, act != 0});
    chk("src", src, 2'(act));
    chk("done", {1'b0, done}, {1'b0, m_done});
    edge_n++;
  endtask

  task automatic run(input int len, input int c_at, input int a_at, input int e_at,
                     input int m_lo, input int m_hi, input int r_at);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < len; i++)
      tick(i == r_at, i == c_at, i == a_at, i == e_at, i >= m_lo && i <= m_hi);
  endtask

  initial begin
    logic m_r;
    run(100, 10, -1, -1, -1, -1, -1);
    run(1210, -1, 0, -1, -1, -1, -1);
    run(1030, 0, -1, 15, -1, -1, -1);
    run(1210, -1, 50, 0, -1, -1, -1);
    run(1010, -1, -1, 0, 5, 50, -1);
    run(1300, 100, 0, -1, -1, -1, 300);
    run(300, 5, 5, 5, -1, -1, -1);
    m_r = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 49) == 0) m_r = ~m_r;
      tick($urandom_range(0, 4999) == 0, $urandom_range(0, 149) == 0,
           $urandom_range(0, 299) == 0, $urandom_range(0, 599) == 0, m_r);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
